// File: rtl/aud_fir_bridge.sv
// Stereo bridge: capture ready/valid -> 16-bit FIR strobe -> saturated 32-bit playback ready/valid.
// Latency: accept to FIR strobe 1 cycle; FIR result to snk_valid 1 cycle (FWFT FIFO).
// Backpressure: src_ready is a credit (fifo_count + pending < FIFO_DEPTH), so FIR results always fit.

// Generic first-word-fall-through FIFO; data reads as zero while empty.
module aud_fir_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_vld_i,
    input  logic [W-1:0]           wr_dat_i,
    output logic                   full_o,
    output logic                   rd_vld_o,
    input  logic                   rd_rdy_i,
    output logic [W-1:0]           rd_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_en;
    logic          rd_en;

    // Status, read port and next pointer/count; push and pop together keep the count.
    always_comb begin
        full_o   = (count_q == FULL_C);
        rd_vld_o = (count_q != '0);
        rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;
        wr_en    = wr_vld_i & ~full_o;
        rd_en    = rd_vld_o & rd_rdy_i;
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        count_o  = count_q;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end
endmodule

// One audio channel: credit gate, 32->16 conversion, FIR return saturation, output FIFO, flags.
module aud_fir_chan #(
    parameter int FIFO_DEPTH = 8,
    parameter int OUT_SHIFT  = 1,
    parameter int ROUND      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] src_dat_i,
    input  logic        src_vld_i,
    output logic        src_rdy_o,
    output logic [15:0] fir_in_dat_o,
    output logic        fir_in_vld_o,
    input  logic [31:0] fir_out_dat_i,
    input  logic        fir_out_vld_i,
    input  logic [1:0]  fir_out_err_i,
    output logic [31:0] snk_dat_o,
    output logic        snk_vld_o,
    input  logic        snk_rdy_i,
    input  logic        stat_clr_i,
    output logic        sat_flag_o,
    output logic        err_flag_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int XW = 32 + OUT_SHIFT;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [CW-1:0]        pending_q, pending_d;
    logic [CW-1:0]        fifo_cnt;
    logic [CW:0]          credit_sum;
    logic                 accept;
    logic [15:0]          conv16;
    logic                 fir_in_vld_q;
    logic [15:0]          fir_in_dat_q;
    logic signed [XW-1:0] ext_s;
    logic signed [XW-1:0] shl_s;
    logic [XW-32:0]       top_bits;
    logic                 in_range;
    logic [31:0]          sat_val;
    logic                 err_any;
    logic                 spurious;
    logic                 good;
    logic [31:0]          push_dat;
    logic                 fifo_full;
    logic                 sat_set;
    logic                 err_set;
    logic                 sat_q;
    logic                 err_q;

    // Credit gate: only registered state feeds src_ready, and it is held low through reset.
    always_comb begin
        credit_sum = {1'b0, fifo_cnt} + {1'b0, pending_q};
        src_rdy_o  = ~reset & (credit_sum < DEPTH_C);
        accept     = src_vld_i & src_rdy_o;
    end

    // 32->16 conversion: round half up, with the single overflow case pinned at +full scale.
    always_comb begin
        conv16 = src_dat_i[31:16];
        if ((ROUND != 0) && src_dat_i[15]) begin
            if (src_dat_i[31:16] == 16'h7FFF) begin
                conv16 = 16'h7FFF;
            end else begin
                conv16 = src_dat_i[31:16] + 16'd1;
            end
        end
    end

    // FIR strobe is a one-cycle pulse following each accept; data holds between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            fir_in_vld_q <= 1'b0;
            fir_in_dat_q <= '0;
        end else begin
            fir_in_vld_q <= accept;
            if (accept) begin
                fir_in_dat_q <= conv16;
            end
        end
    end

    // Return path: widen, shift, clamp to 32 bits; classify spurious and errored results.
    always_comb begin
        ext_s    = XW'($signed(fir_out_dat_i));
        shl_s    = ext_s <<< OUT_SHIFT;
        top_bits = shl_s[XW-1:31];
        in_range = (&top_bits) | ~(|top_bits);
        sat_val  = in_range ? shl_s[31:0] : (shl_s[XW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);
        err_any  = |fir_out_err_i;
        spurious = fir_out_vld_i & (pending_q == '0);
        good     = fir_out_vld_i & ~spurious;
        push_dat = err_any ? 32'h0 : sat_val;
        sat_set  = good & ~err_any & ~in_range;
        err_set  = spurious | (good & err_any) | (good & fifo_full);
    end

    // Outstanding-result count; a simultaneous accept and return cancel out.
    always_comb begin
        pending_d = pending_q;
        case ({accept, good})
            2'b10:   pending_d = pending_q + CW'(1);
            2'b01:   pending_d = pending_q - CW'(1);
            default: pending_d = pending_q;
        endcase
    end

    // Pending counter and sticky flags; a set event beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            sat_q     <= sat_set | (sat_q & ~stat_clr_i);
            err_q     <= err_set | (err_q & ~stat_clr_i);
        end
    end

    aud_fir_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_vld_i (good),
        .wr_dat_i (push_dat),
        .full_o   (fifo_full),
        .rd_vld_o (snk_vld_o),
        .rd_rdy_i (snk_rdy_i),
        .rd_dat_o (snk_dat_o),
        .count_o  (fifo_cnt)
    );

    assign fir_in_vld_o = fir_in_vld_q;
    assign fir_in_dat_o = fir_in_dat_q;
    assign sat_flag_o   = sat_q;
    assign err_flag_o   = err_q;
endmodule

// Top: two independent channel instances sharing only clock, reset and stat_clr.
module aud_fir_bridge #(
    parameter int FIFO_DEPTH = 8,
    parameter int OUT_SHIFT  = 1,
    parameter int ROUND      = 1
) (
    input  logic        clk_clk,
    input  logic        reset,
    input  logic [31:0] src_left_data,
    input  logic        src_left_valid,
    output logic        src_left_ready,
    input  logic [31:0] src_right_data,
    input  logic        src_right_valid,
    output logic        src_right_ready,
    output logic [15:0] fir_left_input_data,
    output logic        fir_left_input_valid,
    output logic [1:0]  fir_left_input_error,
    output logic [15:0] fir_right_input_data,
    output logic        fir_right_input_valid,
    output logic [1:0]  fir_right_input_error,
    input  logic [31:0] fir_left_output_data,
    input  logic        fir_left_output_valid,
    input  logic [1:0]  fir_left_output_error,
    input  logic [31:0] fir_right_output_data,
    input  logic        fir_right_output_valid,
    input  logic [1:0]  fir_right_output_error,
    output logic [31:0] snk_left_data,
    output logic        snk_left_valid,
    input  logic        snk_left_ready,
    output logic [31:0] snk_right_data,
    output logic        snk_right_valid,
    input  logic        snk_right_ready,
    input  logic        stat_clr,
    output logic [1:0]  sat_flag,
    output logic [1:0]  err_flag
);
    logic sat_l, sat_r, err_l, err_r;

    aud_fir_chan #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .OUT_SHIFT  (OUT_SHIFT),
        .ROUND      (ROUND)
    ) u_left (
        .clk           (clk_clk),
        .reset         (reset),
        .src_dat_i     (src_left_data),
        .src_vld_i     (src_left_valid),
        .src_rdy_o     (src_left_ready),
        .fir_in_dat_o  (fir_left_input_data),
        .fir_in_vld_o  (fir_left_input_valid),
        .fir_out_dat_i (fir_left_output_data),
        .fir_out_vld_i (fir_left_output_valid),
        .fir_out_err_i (fir_left_output_error),
        .snk_dat_o     (snk_left_data),
        .snk_vld_o     (snk_left_valid),
        .snk_rdy_i     (snk_left_ready),
        .stat_clr_i    (stat_clr),
        .sat_flag_o    (sat_l),
        .err_flag_o    (err_l)
    );

    aud_fir_chan #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .OUT_SHIFT  (OUT_SHIFT),
        .ROUND      (ROUND)
    ) u_right (
        .clk           (clk_clk),
        .reset         (reset),
        .src_dat_i     (src_right_data),
        .src_vld_i     (src_right_valid),
        .src_rdy_o     (src_right_ready),
        .fir_in_dat_o  (fir_right_input_data),
        .fir_in_vld_o  (fir_right_input_valid),
        .fir_out_dat_i (fir_right_output_data),
        .fir_out_vld_i (fir_right_output_valid),
        .fir_out_err_i (fir_right_output_error),
        .snk_dat_o     (snk_right_data),
        .snk_vld_o     (snk_right_valid),
        .snk_rdy_i     (snk_right_ready),
        .stat_clr_i    (stat_clr),
        .sat_flag_o    (sat_r),
        .err_flag_o    (err_r)
    );

    assign fir_left_input_error  = 2'b00;
    assign fir_right_input_error = 2'b00;
    assign sat_flag              = {sat_r, sat_l};
    assign err_flag              = {err_r, err_l};
endmodule

// File: tb/tb_aud_fir_bridge.sv
module tb_aud_fir_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] src_data [2];
    logic        src_valid [2];
    logic        src_ready [2];
    logic [15:0] fir_in_dat [2];
    logic        fir_in_vld [2];
    logic [1:0]  fir_in_err [2];
    logic [31:0] fir_out_dat [2];
    logic        fir_out_vld [2];
    logic [1:0]  fir_out_err [2];
    logic [31:0] snk_data [2];
    logic        snk_valid [2];
    logic        snk_ready [2];
    logic        stat_clr;
    logic [1:0]  sat_flag;
    logic [1:0]  err_flag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aud_fir_bridge #(.FIFO_DEPTH(8), .OUT_SHIFT(1), .ROUND(1)) dut (
        .clk_clk                (clk),
        .reset                  (reset),
        .src_left_data          (src_data[0]),
        .src_left_valid         (src_valid[0]),
        .src_left_ready         (src_ready[0]),
        .src_right_data         (src_data[1]),
        .src_right_valid        (src_valid[1]),
        .src_right_ready        (src_ready[1]),
        .fir_left_input_data    (fir_in_dat[0]),
        .fir_left_input_valid   (fir_in_vld[0]),
        .fir_left_input_error   (fir_in_err[0]),
        .fir_right_input_data   (fir_in_dat[1]),
        .fir_right_input_valid  (fir_in_vld[1]),
        .fir_right_input_error  (fir_in_err[1]),
        .fir_left_output_data   (fir_out_dat[0]),
        .fir_left_output_valid  (fir_out_vld[0]),
        .fir_left_output_error  (fir_out_err[0]),
        .fir_right_output_data  (fir_out_dat[1]),
        .fir_right_output_valid (fir_out_vld[1]),
        .fir_right_output_error (fir_out_err[1]),
        .snk_left_data          (snk_data[0]),
        .snk_left_valid         (snk_valid[0]),
        .snk_left_ready         (snk_ready[0]),
        .snk_right_data         (snk_data[1]),
        .snk_right_valid        (snk_valid[1]),
        .snk_right_ready        (snk_ready[1]),
        .stat_clr               (stat_clr),
        .sat_flag               (sat_flag),
        .err_flag               (err_flag)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Reference: floor((x + 0.5 LSB16) / 2^16) clamped at +full scale, then x2 clamped to int32.
    function automatic logic [31:0] model(input logic [31:0] d);
        longint v;
        longint r;
        v = longint'($signed(d));
        r = (v + 32768) >>> 16;
        if (r > 32767) r = 32767;
        r = r * 2;
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
        return r[31:0];
    endfunction

    // FIR stand-in: sign-extend the 16-bit input, 4-stage delay; manual drive when auto is off.
    logic        auto_fir;
    logic [15:0] pd [2][4];
    logic        pv [2][4];
    logic [31:0] man_dat [2];
    logic        man_vld [2];
    logic [1:0]  man_err [2];

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            for (int s = 3; s > 0; s--) begin
                pd[c][s] <= pd[c][s-1];
                pv[c][s] <= pv[c][s-1];
            end
            pd[c][0] <= fir_in_dat[c];
            pv[c][0] <= auto_fir & fir_in_vld[c];
        end
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            fir_out_vld[c] = auto_fir ? pv[c][3] : man_vld[c];
            fir_out_dat[c] = auto_fir ? {{16{pd[c][3][15]}}, pd[c][3]} : man_dat[c];
            fir_out_err[c] = auto_fir ? 2'b00 : man_err[c];
        end
    end

    // Monitor: record accepts and pops; a stalled output must hold its value.
    logic [31:0] acc0[$], acc1[$], got0[$], got1[$];
    bit          hold [2];
    logic [31:0] hold_dat [2];

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!reset && src_valid[c] && src_ready[c]) begin
                if (c == 0) acc0.push_back(src_data[c]); else acc1.push_back(src_data[c]);
            end
            if (snk_valid[c] && snk_ready[c]) begin
                if (c == 0) got0.push_back(snk_data[c]); else got1.push_back(snk_data[c]);
            end
            if (hold[c]) begin
                chk("snk_hold_vld", 32'(snk_valid[c]), 32'd1);
                chk("snk_hold_dat", snk_data[c], hold_dat[c]);
            end
            hold[c]     = snk_valid[c] && !snk_ready[c] && !reset;
            hold_dat[c] = snk_data[c];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        acc0.delete(); acc1.delete(); got0.delete(); got1.delete();
    endtask

    task automatic wait_got(input int c, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((c == 0 ? got0.size() : got1.size()) >= n) break;
            tick();
        end
        if ((c == 0 ? got0.size() : got1.size()) < n) begin
            total++; bad++;
            $display("FAIL wait_out ch%0d: got %0d outputs want %0d", c, (c == 0 ? got0.size() : got1.size()), n);
        end
    endtask

    task automatic drain_cmp();
        while (got0.size() > 0) begin
            if (acc0.size() == 0) begin
                total++; bad++; $display("FAIL extra_out ch0: got %h want none", got0.pop_front());
            end else chk("rnd_out_l", got0.pop_front(), model(acc0.pop_front()));
        end
        while (got1.size() > 0) begin
            if (acc1.size() == 0) begin
                total++; bad++; $display("FAIL extra_out ch1: got %h want none", got1.pop_front());
            end else chk("rnd_out_r", got1.pop_front(), model(acc1.pop_front()));
        end
    endtask

    typedef struct {logic [31:0] src; logic [15:0] f16; logic [31:0] snk;} va_t;
    typedef struct {int ch; logic [31:0] ret; logic [1:0] err; logic [31:0] snk; logic s; logic e;} vb_t;
    va_t ta [6];
    vb_t tb_ [8];

    initial begin
        logic [1:0] ef;
        logic [1:0] sf;
        logic [31:0] spec [4];
        int c;

        ta[0] = '{32'h1234_8000, 16'h1235, 32'h0000_246A};
        ta[1] = '{32'h7FFF_FFFF, 16'h7FFF, 32'h0000_FFFE};
        ta[2] = '{32'h8000_0000, 16'h8000, 32'hFFFF_0000};
        ta[3] = '{32'hFFFF_8000, 16'h0000, 32'h0000_0000};
        ta[4] = '{32'h1234_7FFF, 16'h1234, 32'h0000_2468};
        ta[5] = '{32'h8000_8000, 16'h8001, 32'hFFFF_0002};
        tb_[0] = '{0, 32'h4000_0000, 2'b00, 32'h7FFF_FFFF, 1'b1, 1'b0};
        tb_[1] = '{0, 32'hBFFF_FFFF, 2'b00, 32'h8000_0000, 1'b1, 1'b0};
        tb_[2] = '{0, 32'hC000_0000, 2'b00, 32'h8000_0000, 1'b0, 1'b0};
        tb_[3] = '{1, 32'h0000_1234, 2'b00, 32'h0000_2468, 1'b0, 1'b0};
        tb_[4] = '{1, 32'h3FFF_FFFF, 2'b00, 32'h7FFF_FFFE, 1'b0, 1'b0};
        tb_[5] = '{0, 32'h1234_5678, 2'b01, 32'h0000_0000, 1'b0, 1'b1};
        tb_[6] = '{1, 32'h7FFF_0000, 2'b10, 32'h0000_0000, 1'b0, 1'b1};
        tb_[7] = '{1, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFE, 1'b0, 1'b0};
        spec[0] = 32'h7FFF_FFFF; spec[1] = 32'h8000_0000; spec[2] = 32'h7FFF_8000; spec[3] = 32'hFFFF_8000;

        reset = 1'b1; auto_fir = 1'b0; stat_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            src_data[k] = '0; src_valid[k] = 1'b0; snk_ready[k] = 1'b0;
            man_dat[k] = '0; man_vld[k] = 1'b0; man_err[k] = 2'b00;
        end

        // Reset state
        repeat (6) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_src_ready", 32'(src_ready[k]), 32'd0);
            chk("rst_fir_vld", 32'(fir_in_vld[k]), 32'd0);
            chk("rst_fir_dat", 32'(fir_in_dat[k]), 32'd0);
            chk("rst_fir_err", 32'(fir_in_err[k]), 32'd0);
            chk("rst_snk_vld", 32'(snk_valid[k]), 32'd0);
            chk("rst_snk_dat", snk_data[k], 32'd0);
        end
        chk("rst_sat", 32'(sat_flag), 32'd0);
        chk("rst_err", 32'(err_flag), 32'd0);
        reset = 1'b0;
        tick();
        chk("ready_after_rst_l", 32'(src_ready[0]), 32'd1);
        chk("ready_after_rst_r", 32'(src_ready[1]), 32'd1);

        // Forward conversion table, FIR in the loop
        auto_fir = 1'b1; snk_ready[0] = 1'b1; snk_ready[1] = 1'b1;
        clear_q();
        for (int i = 0; i < 6; i++) begin
            c = i % 2;
            src_valid[c] = 1'b1; src_data[c] = ta[i].src;
            tick();
            src_valid[c] = 1'b0;
            chk("fir_strobe", 32'(fir_in_vld[c]), 32'd1);
            chk("fir_data", 32'(fir_in_dat[c]), 32'(ta[i].f16));
            tick();
            chk("fir_strobe_once", 32'(fir_in_vld[c]), 32'd0);
            wait_got(c, 1, 40);
            if (c == 0 && got0.size() > 0) chk("fwd_snk_l", got0.pop_front(), ta[i].snk);
            if (c == 1 && got1.size() > 0) chk("fwd_snk_r", got1.pop_front(), ta[i].snk);
            clear_q();
        end
        chk("fwd_sat", 32'(sat_flag), 32'd0);
        chk("fwd_err", 32'(err_flag), 32'd0);

        // Return-path table, FIR driven by hand
        auto_fir = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 8; i++) begin
            c = tb_[i].ch;
            src_valid[c] = 1'b1; src_data[c] = 32'h0101_0000;
            tick();
            src_valid[c] = 1'b0;
            tick();
            man_vld[c] = 1'b1; man_dat[c] = tb_[i].ret; man_err[c] = tb_[i].err;
            tick();
            man_vld[c] = 1'b0; man_err[c] = 2'b00;
            wait_got(c, 1, 20);
            if (c == 0 && got0.size() > 0) chk("ret_snk_l", got0.pop_front(), tb_[i].snk);
            if (c == 1 && got1.size() > 0) chk("ret_snk_r", got1.pop_front(), tb_[i].snk);
            sf = 2'b00; sf[c] = tb_[i].s;
            ef = 2'b00; ef[c] = tb_[i].e;
            chk("ret_sat", 32'(sat_flag), 32'(sf));
            chk("ret_err", 32'(err_flag), 32'(ef));
            stat_clr = 1'b1;
            tick();
            stat_clr = 1'b0;
            chk("clr_sat", 32'(sat_flag), 32'd0);
            chk("clr_err", 32'(err_flag), 32'd0);
            clear_q();
        end

        // Spurious return on right, clear, and set-beats-clear
        man_vld[1] = 1'b1; man_dat[1] = 32'h0000_1111;
        tick();
        man_vld[1] = 1'b0;
        chk("spur_err", 32'(err_flag), 32'h2);
        repeat (3) tick();
        chk("spur_no_out_vld", 32'(snk_valid[1]), 32'd0);
        chk("spur_no_out", 32'(got1.size()), 32'd0);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("spur_clr", 32'(err_flag), 32'd0);
        man_vld[1] = 1'b1; stat_clr = 1'b1;
        tick();
        man_vld[1] = 1'b0; stat_clr = 1'b0;
        chk("set_beats_clr", 32'(err_flag), 32'h2);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clr_again", 32'(err_flag), 32'd0);

        // Backpressure: exactly FIFO_DEPTH accepts, then ordered drain
        auto_fir = 1'b1; snk_ready[0] = 1'b0; clear_q();
        src_valid[0] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            src_data[0] = 32'h0100_0000 * (k + 1) + 32'h8000;
            tick();
        end
        src_valid[0] = 1'b0;
        chk("bp_accepts", 32'(acc0.size()), 32'd8);
        chk("bp_ready_low", 32'(src_ready[0]), 32'd0);
        chk("bp_snk_vld", 32'(snk_valid[0]), 32'd1);
        snk_ready[0] = 1'b1;
        wait_got(0, 8, 60);
        for (int k = 0; k < 8; k++) begin
            if (got0.size() > 0 && acc0.size() > 0) chk("bp_order", got0.pop_front(), model(acc0.pop_front()));
        end
        chk("bp_err", 32'(err_flag), 32'd0);
        chk("bp_ready_back", 32'(src_ready[0]), 32'd1);
        clear_q();

        // Random traffic on both channels against the reference
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 2; k++) begin
                src_valid[k] = ($urandom_range(0, 3) != 0);
                src_data[k]  = ($urandom_range(0, 4) == 0) ? spec[$urandom_range(0, 3)] : $urandom;
                snk_ready[k] = $urandom_range(0, 1) != 0;
            end
            tick();
            drain_cmp();
            chk("credit_l", 32'(acc0.size() <= 8), 32'd1);
            chk("credit_r", 32'(acc1.size() <= 8), 32'd1);
        end
        src_valid[0] = 1'b0; src_valid[1] = 1'b0;
        snk_ready[0] = 1'b1; snk_ready[1] = 1'b1;
        for (int n = 0; n < 60 && (acc0.size() + acc1.size()) > 0; n++) begin
            tick();
            drain_cmp();
        end
        chk("rnd_left_lost", 32'(acc0.size()), 32'd0);
        chk("rnd_right_lost", 32'(acc1.size()), 32'd0);
        chk("rnd_sat", 32'(sat_flag), 32'd0);
        chk("rnd_err", 32'(err_flag), 32'd0);

        // Reset with results in flight: late returns are spurious
        clear_q();
        src_valid[0] = 1'b1; src_data[0] = 32'h2000_0000;
        tick();
        tick();
        src_valid[0] = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (12) tick();
        chk("midrst_err", 32'(err_flag), 32'h1);
        chk("midrst_no_out", 32'(got0.size()), 32'd0);
        chk("midrst_snk_vld", 32'(snk_valid[0]), 32'd0);
        chk("midrst_ready", 32'(src_ready[0]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aud_fir_bridge.md
Name: aud_fir_bridge

Overview:
- Stereo streaming bridge between the audio-core capture streams and the two FIR filter instances, and back into the audio-core playback streams.
- Per channel it accepts 32-bit ready/valid samples and rounds/saturates them to 16 bits for the FIR, which has no backpressure.
- It converts the 32-bit FIR result back to a saturated 32-bit sample, buffers it in a FIFO, and presents it to the playback sink with ready/valid.
- A credit scheme guarantees that no FIR result is ever lost.

Parameters:
- FIFO_DEPTH, 8: output FIFO entries per channel; power of two, >=2.
- OUT_SHIFT, 1: left shift applied to the FIR result before 32-bit saturation; range 0..15.
- ROUND, 1: 1 = round-half-up on the 32->16 conversion; 0 = truncate.

Ports:
Ports written {left,right} exist once per channel, with identical behaviour.
- clk_clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- src_{left,right}_data  in  32  capture sample, signed, MSB-aligned.
- src_{left,right}_valid  in  1  capture sample valid.
- src_{left,right}_ready  out  1  bridge can accept a capture sample.
- fir_{left,right}_input_data  out  16  sample to FIR.
- fir_{left,right}_input_valid  out  1  one-cycle FIR strobe.
- fir_{left,right}_input_error  out  2  tied 2'b00.
- fir_{left,right}_output_data  in  32  FIR result, signed.
- fir_{left,right}_output_valid  in  1  FIR result strobe.
- fir_{left,right}_output_error  in  2  FIR error code.
- snk_{left,right}_data  out  32  playback sample.
- snk_{left,right}_valid  out  1  playback sample valid.
- snk_{left,right}_ready  in  1  playback sink ready.
- stat_clr  in  1  clears all sticky flags.
- sat_flag  out  2  sticky saturation flags; [0] = left, [1] = right.
- err_flag  out  2  sticky FIR-error / protocol-error flags; [0] = left, [1] = right.

Behaviour:
The two channels are fully independent; nothing below couples left and right.

Reset (synchronous, active-high):
- All valids 0, all data 0, src_ready 0 during reset.
- FIFOs empty, pending counters 0, flags 0.

Credit:
- pending = number of samples accepted from src whose FIR result has not yet returned.
- src_ready = (fifo_count + pending < FIFO_DEPTH); registered-state only, no combinational path from snk_ready.
- Accept = src_valid & src_ready; pending increments on accept.
- pending decrements on fir_output_valid.
- Accept and fir_output_valid in the same cycle: pending unchanged.

Forward path:
- Accept at cycle T -> fir_input_valid = 1 for exactly cycle T+1.
- fir_input_data at T+1 = conv16(src_data sampled at T).
- conv16 with ROUND=1: hi = data[31:16] + data[15]; if data[31:16] = 16'h7FFF and data[15] = 1, the result is 16'h7FFF (positive saturation, no flag).
- conv16 with ROUND=0: data[31:16].

Return path:
- fir_output_valid at cycle U:
  - Error = 0: the FIFO write value is sat32(fir_output_data <<< OUT_SHIFT).
    - Computed at 32+OUT_SHIFT bits, then clamped to [32'h8000_0000, 32'h7FFF_FFFF].
    - Clamping sets sat_flag.
  - fir_output_error != 0: write 32'h0 and set err_flag.
- Spurious fir_output_valid with pending = 0: discard the sample, set err_flag, pending stays 0.
- The FIFO cannot overflow under the credit scheme. If the FIFO is full on a write, the write is dropped and err_flag is set.

Sink:
- First-word-fall-through FIFO.
- Write at U into an empty FIFO -> snk_valid = 1 at U+1.
- Pop on snk_valid & snk_ready.
- Simultaneous push and pop leaves fifo_count unchanged.
- snk_data is stable while snk_valid & !snk_ready.

Flags:
- Sticky until stat_clr.
- stat_clr and a set event in the same cycle: set wins.

Reset mid-operation:
- Results in flight are discarded.
- Any fir_output_valid arriving after reset is treated as spurious (err_flag set).

Test Plan:
1. Left src 32'h1234_8000, snk_ready = 1, FIR modelled as identity-extend (output = input, sign-extended, latency 4) -> fir_left_input_data = 16'h1235 one cycle after accept; snk_left_data = 32'h0000_246A with OUT_SHIFT=1; sat_flag = 0.
2. src 32'h7FFF_FFFF and 32'h8000_0000 -> FIR inputs 16'h7FFF and 16'h8000; no flags set.
3. FIR returns 32'h4000_0000 and 32'hBFFF_FFFF with OUT_SHIFT=1 -> snk_data 32'h7FFF_FFFF and 32'h8000_0000, sat_flag[0] = 1. A return of 32'hC000_0000 -> 32'h8000_0000 with no saturation.
4. snk_ready = 0, src continuously valid, FIFO_DEPTH = 8 -> exactly 8 accepts, then src_ready = 0. Releasing snk_ready drains 8 samples in order, with no loss and no err_flag.
5. fir_right_output_valid with pending = 0 -> err_flag = 2'b10 and no FIFO write. Then stat_clr pulse -> err_flag = 0. Also check: fir_output_error = 2'b01 -> sample 0 written and err_flag set.
6. Accept and fir_output_valid in the same cycle, and push and pop in the same cycle, under random snk_ready -> pending and fifo_count are consistent. Scoreboard shows in-order, lossless output on both channels.
